// File: rtl/store_merge_unit.sv
// Store merge unit: word/halfword/byte stores, sub-word via read-modify-write.
// Optional MISALIGN_TRAP_EN turns misaligned halfword/word stores into a trap.
module store_merge_unit #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        SSCtrl,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] Data_B,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr,
  output logic [DATA_W-1:0] Data_out,
  output logic              busy,
  output logic              done,
  output logic              misalign
);

  localparam int LANES = DATA_W / 8;
  localparam int OFS_W = $clog2(LANES);

  typedef enum logic [2:0] {
    IDLE, READ, WAIT, WRITE, DONE
  } st_t;

  st_t               st_q, st_d;
  logic [OFS_W-1:0]  ofs_q;
  logic [1:0]        ctl_q;
  logic [15:0]       bdat_q;
  logic [DATA_W-1:0] out_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        cnt_q;
  logic [DATA_W-1:0] merged;
  logic              mis;
  logic              accept;
  logic              rd_last;
  int                ofs_i;

  assign accept  = (st_q == IDLE) && start;
  assign rd_last = (st_q == WAIT) && (cnt_q == 3'(MEM_RD_LAT));
  assign ofs_i   = 32'(ofs_q);

`ifdef MISALIGN_TRAP_EN
  logic mis_q;

  assign mis = ((SSCtrl == 2'b10) && Addr[0])
            || ((SSCtrl == 2'b01) && (Addr[OFS_W-1:0] != '0));
  assign misalign = (st_q == DONE) && mis_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      mis_q <= 1'b0;
    else if (accept) mis_q <= mis;
  end
`else
  assign mis      = 1'b0;
  assign misalign = 1'b0;
`endif

  // Halfword at the top lane loses its upper byte: no wrap to lane 0.
  always_comb begin
    merged = mem_rdata;
    for (int k = 0; k < LANES; k++) begin
      if (k == ofs_i)
        merged[8*k +: 8] = bdat_q[7:0];
      if ((ctl_q == 2'b10) && (k == ofs_i + 1))
        merged[8*k +: 8] = bdat_q[15:8];
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE: begin
        if (start) begin
          unique case (1'b1)
            (SSCtrl == 2'b00) || mis: st_d = DONE;
            (SSCtrl == 2'b01):        st_d = WRITE;
            default:                  st_d = READ;
          endcase
        end
      end
      READ:  st_d = WAIT;
      WAIT:  if (rd_last) st_d = WRITE;
      WRITE: st_d = DONE;
      DONE:  st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= IDLE;
      ofs_q  <= '0;
      ctl_q  <= '0;
      bdat_q <= '0;
      out_q  <= '0;
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      st_q <= st_d;
      if (accept) begin
        addr_q <= {Addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
        ofs_q  <= Addr[OFS_W-1:0];
        ctl_q  <= SSCtrl;
        bdat_q <= Data_B[15:0];
        if (SSCtrl == 2'b01)
          out_q <= Data_B;
      end
      if (st_q == READ)
        cnt_q <= 3'd1;
      else if ((st_q == WAIT) && !rd_last)
        cnt_q <= cnt_q + 3'd1;
      if (rd_last)
        out_q <= merged;
    end
  end

  assign mem_addr = addr_q;
  assign Data_out = out_q;
  assign mem_rd   = (st_q == READ);
  assign mem_wr   = (st_q == WRITE);
  assign done     = (st_q == DONE);
  assign busy     = (st_q == READ) || (st_q == WAIT)
                 || (st_q == WRITE);

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: one DUT with read latency 1,
// one with read latency 3, each with its own latency-accurate memory.
module tb_store_merge_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  SSCtrl;
  logic [31:0] Addr;
  logic [31:0] Data_B;
  logic [31:0] mword;

  logic [31:0] addr1, addr3, dout1, dout3;
  logic [31:0] rdata1, rdata3;
  logic        rd1, rd3, wr1, wr3;
  logic        bsy1, bsy3, dn1, dn3, ms1, ms3;
  logic        rd1_q;
  logic [2:0]  rd3_q;

  logic        sel;
  logic [31:0] o_addr, o_dout;
  logic        o_rd, o_wr, o_busy, o_done, o_ms;

  int checks = 0;
  int failures = 0;

  store_merge_unit #(.DATA_W(32), .ADDR_W(32), .MEM_RD_LAT(1)) u1 (
    .clk(clk), .reset(reset), .start(start), .SSCtrl(SSCtrl),
    .Addr(Addr), .Data_B(Data_B), .mem_addr(addr1),
    .mem_rd(rd1), .mem_rdata(rdata1), .mem_wr(wr1),
    .Data_out(dout1), .busy(bsy1), .done(dn1), .misalign(ms1)
  );

  store_merge_unit #(.DATA_W(32), .ADDR_W(32), .MEM_RD_LAT(3)) u3 (
    .clk(clk), .reset(reset), .start(start), .SSCtrl(SSCtrl),
    .Addr(Addr), .Data_B(Data_B), .mem_addr(addr3),
    .mem_rd(rd3), .mem_rdata(rdata3), .mem_wr(wr3),
    .Data_out(dout3), .busy(bsy3), .done(dn3), .misalign(ms3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read data is only meaningful in the cycle the latency says.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd1_q <= 1'b0;
      rd3_q <= 3'b0;
    end else begin
      rd1_q <= rd1;
      rd3_q <= {rd3_q[1:0], rd3};
    end
  end

  assign rdata1 = rd1_q    ? mword : 32'hDEAD0001;
  assign rdata3 = rd3_q[2] ? mword : 32'hDEAD0003;

  assign o_addr = sel ? addr3 : addr1;
  assign o_dout = sel ? dout3 : dout1;
  assign o_rd   = sel ? rd3   : rd1;
  assign o_wr   = sel ? wr3   : wr1;
  assign o_busy = sel ? bsy3  : bsy1;
  assign o_done = sel ? dn3   : dn1;
  assign o_ms   = sel ? ms3   : ms1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(
    input  bit          s,
    input  logic [1:0]  ctl,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [31:0] rw,
    input  int          inj,
    output int          rd_c,
    output int          wr_c,
    output int          dn_c,
    output int          ms_c,
    output int          nrd,
    output int          nwr,
    output int          nbd,
    output logic [31:0] rda,
    output logic [31:0] wra,
    output logic [31:0] wdat
  );
    rd_c = -1; wr_c = -1; dn_c = -1; ms_c = -1;
    nrd = 0; nwr = 0; nbd = 0;
    rda = '0; wra = '0; wdat = '0;
    sel = s;
    mword = rw;
    start = 1'b1;
    SSCtrl = ctl;
    Addr = a;
    Data_B = d;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (o_rd) begin
        nrd++; rd_c = c; rda = o_addr;
      end
      if (o_wr) begin
        nwr++; wr_c = c; wra = o_addr; wdat = o_dout;
      end
      if (o_done) begin
        dn_c = c;
        if (o_busy) nbd++;
      end
      if (o_ms) ms_c = c;
      if (c == inj) begin
        start = 1'b1;
        SSCtrl = 2'b01;
        Addr = 32'h0000_0500;
        Data_B = 32'h1234_5678;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  int rd_c, wr_c, dn_c, ms_c, nrd, nwr, nbd;
  logic [31:0] rda, wra, wdat;
  int nw;

  initial begin
    reset = 1'b0;
    start = 1'b0;
    SSCtrl = 2'b00;
    Addr = '0;
    Data_B = '0;
    mword = '0;
    sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {30'b0, bsy1, bsy3}, 32'h0);
    chk("rst_done", {30'b0, dn1, dn3}, 32'h0);
    chk("rst_strb", {28'b0, rd1, rd3, wr1, wr3}, 32'h0);
    chk("rst_mis", {30'b0, ms1, ms3}, 32'h0);
    chk("rst_dout", dout1 | dout3, 32'h0);
    chk("rst_addr", addr1 | addr3, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Word store: direct write, no read.
    run_op(0, 2'b01, 32'h104, 32'hDEADBEEF, 32'h0, 0,
           rd_c, wr_c, dn_c, ms_c, nrd, nwr, nbd, rda, wra, wdat);
    chk("w_nrd", nrd, 0);
    chk("w_wrc", wr_c, 1);
    chk("w_nwr", nwr, 1);
    chk("w_addr", wra, 32'h104);
    chk("w_data", wdat, 32'hDEADBEEF);
    chk("w_done", dn_c, 2);
    chk("w_bsydn", nbd, 0);

    // Byte store, latency 1.
    run_op(0, 2'b11, 32'h203, 32'h000000AB, 32'h11223344, 0,
           rd_c, wr_c, dn_c, ms_c, nrd, nwr, nbd, rda, wra, wdat);
    chk("b_rdc", rd_c, 1);
    chk("b_nrd", nrd, 1);
    chk("b_rda", rda, 32'h200);
    chk("b_wrc", wr_c, 3);
    chk("b_data", wdat, 32'hAB223344);
    chk("b_wra", wra, 32'h200);
    chk("b_done", dn_c, 4);

    // Halfword store, latency 3.
    run_op(1, 2'b10, 32'h302, 32'h0000CAFE, 32'h55667788, 0,
           rd_c, wr_c, dn_c, ms_c, nrd, nwr, nbd, rda, wra, wdat);
    chk("h_rdc", rd_c, 1);
    chk("h_rda", rda, 32'h300);
    chk("h_wrc", wr_c, 5);
    chk("h_data", wdat, 32'hCAFE7788);
    chk("h_done", dn_c, 6);
    chk("h_bsydn", nbd, 0);

    // Start pulsed while busy in WAIT must be ignored.
    run_op(1, 2'b11, 32'h100, 32'h0000005A, 32'hAABBCCDD, 2,
           rd_c, wr_c, dn_c, ms_c, nrd, nwr, nbd, rda, wra, wdat);
    chk("ig_nwr", nwr, 1);
    chk("ig_wrc", wr_c, 5);
    chk("ig_wra", wra, 32'h100);
    chk("ig_data", wdat, 32'hAABBCC5A);
    chk("ig_done", dn_c, 6);

    // No-op: done next cycle, no strobes.
    run_op(0, 2'b00, 32'h700, 32'hFFFFFFFF, 32'h0, 0,
           rd_c, wr_c, dn_c, ms_c, nrd, nwr, nbd, rda, wra, wdat);
    chk("n_done", dn_c, 1);
    chk("n_strb", nrd + nwr, 0);

    // Halfword at top lane: upper byte dropped.
    run_op(0, 2'b10, 32'h007, 32'h0000BEEF, 32'h11223344, 0,
           rd_c, wr_c, dn_c, ms_c, nrd, nwr, nbd, rda, wra, wdat);
    chk("top_data", wdat, 32'hEF223344);
    chk("top_rda", rda, 32'h004);

    // Misaligned halfword.
    run_op(0, 2'b10, 32'h401, 32'h00001234, 32'h99887766, 0,
           rd_c, wr_c, dn_c, ms_c, nrd, nwr, nbd, rda, wra, wdat);
`ifdef MISALIGN_TRAP_EN
    chk("mh_mis", ms_c, 1);
    chk("mh_done", dn_c, 1);
    chk("mh_strb", nrd + nwr, 0);
`else
    chk("mh_mis", ms_c, -1);
    chk("mh_rda", rda, 32'h400);
    chk("mh_wrc", wr_c, 3);
    chk("mh_data", wdat, 32'h99123466);
    chk("mh_done", dn_c, 4);
`endif

    // Misaligned word.
    run_op(1, 2'b01, 32'h106, 32'hCAFEF00D, 32'h0, 0,
           rd_c, wr_c, dn_c, ms_c, nrd, nwr, nbd, rda, wra, wdat);
`ifdef MISALIGN_TRAP_EN
    chk("mw_mis", ms_c, 1);
    chk("mw_done", dn_c, 1);
    chk("mw_strb", nrd + nwr, 0);
`else
    chk("mw_mis", ms_c, -1);
    chk("mw_nrd", nrd, 0);
    chk("mw_wra", wra, 32'h104);
    chk("mw_data", wdat, 32'hCAFEF00D);
    chk("mw_done", dn_c, 2);
`endif

    // Reset asserted during WAIT aborts immediately.
    sel = 1'b1;
    mword = 32'h01020304;
    start = 1'b1;
    SSCtrl = 2'b11;
    Addr = 32'h0000_0601;
    Data_B = 32'h000000EE;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("ra_busy", {31'b0, bsy3}, 32'h1);
    reset = 1'b0;
    #1;
    chk("ra_busy0", {31'b0, bsy3}, 32'h0);
    chk("ra_strb", {30'b0, rd3, wr3}, 32'h0);
    chk("ra_done", {30'b0, dn3, ms3}, 32'h0);
    chk("ra_dout", dout3, 32'h0);
    chk("ra_addr", addr3, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    nw = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (wr3 || rd3 || bsy3) nw++;
    end
    chk("ra_nowr", nw, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
